hazard_unit_param: RTL

- Parametrised hazard controller for the 5-stage pipelined RV32 core; successor to the fixed 1-cycle load-use / branch-flush unit.
- Adds:
  - configurable load-use bubble length
  - configurable branch flush depth
  - per-operand use qualification
  - a data-memory busy freeze
- Outputs are same-cycle (Mealy) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, driven by a small registered FSM.

---
 rtl/hazard_unit_param_if.sv | 50 +++++
 rtl/hazard_unit_param.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hazard_unit_param_if.sv
// rtl/hazard_unit_param_if.sv - hazard unit signal bundle; perf counter fields exist only with HAZARD_PERF_CNT_EN
// The master modport is the pipeline side and the slave modport is the hazard unit side.
interface hazard_unit_param_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  branch_taken;
    logic                  dmem_busy;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_write;
    logic                  exmem_write;
    logic                  memwb_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_flush;
    logic                  stall_active;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           perf_stall_cycles;
    logic [31:0]           perf_flush_count;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd, branch_taken, dmem_busy,
        input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
        input  ifid_flush, idex_flush, exmem_flush, stall_active
`ifdef HAZARD_PERF_CNT_EN
        ,
        input  perf_stall_cycles, perf_flush_count
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd, branch_taken, dmem_busy,
        output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
        output ifid_flush, idex_flush, exmem_flush, stall_active
`ifdef HAZARD_PERF_CNT_EN
        ,
        output perf_stall_cycles, perf_flush_count
`endif
    );
endinterface

// File: rtl/hazard_unit_param.sv
// rtl/hazard_unit_param.sv - parametrised load-use/branch/dmem-freeze hazard controller; optional HAZARD_PERF_CNT_EN counters
// Mealy pipeline-register controls from a two-state FSM that counts extra load-use bubbles.
module hazard_unit_param #(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_unit_param_if.slave   hz
);
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LSTALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_STALL_RELOAD = CNT_W'(LOAD_STALL - 1);
    localparam logic             C_MULTI_STALL  = (LOAD_STALL > 1);
    localparam logic             C_DEEP_FLUSH   = (FLUSH_DEPTH == 3);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic w_luh;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_write;
    logic w_exmem_write;
    logic w_memwb_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_stall_active;

    // x0 is hard-wired zero, so a load targeting it can never produce a hazard.
    assign w_luh = hz.ex_mem_read && (hz.ex_rd != '0) &&
                   ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                    (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_write   = 1'b1;
        w_exmem_write  = 1'b1;
        w_memwb_write  = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_flush  = 1'b0;
        w_stall_active = 1'b0;

        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_write = 1'b0;
        end else if (hz.dmem_busy) begin
            // Whole pipeline frozen; a pending stall stays visible but nothing advances.
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_write  = 1'b0;
            w_memwb_write  = 1'b0;
            w_stall_active = (r_state == S_LSTALL);
        end else if (hz.branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = C_DEEP_FLUSH;
            w_next_state  = S_IDLE;
            w_next_cnt    = '0;
        end else if (r_state == S_LSTALL) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_flush   = 1'b1;
            w_stall_active = 1'b1;
            w_next_cnt     = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                w_next_state = S_IDLE;
            end
        end else if (w_luh) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_flush   = 1'b1;
            w_stall_active = 1'b1;
            if (C_MULTI_STALL) begin
                w_next_state = S_LSTALL;
                w_next_cnt   = C_STALL_RELOAD;
            end
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.ifid_write   = w_ifid_write;
    assign hz.idex_write   = w_idex_write;
    assign hz.exmem_write  = w_exmem_write;
    assign hz.memwb_write  = w_memwb_write;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.exmem_flush  = w_exmem_flush;
    assign hz.stall_active = w_stall_active;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_active && !hz.dmem_busy) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_ifid_flush) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cycles = r_perf_stall;
    assign hz.perf_flush_count  = r_perf_flush;
`endif
endmodule
